// File: rtl/fft_pkg.sv
// Shared FFT definitions: coefficient FSM states plus the twiddle exponent and
// conjugation helpers used by the twiddle vector generator.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Exponent for butterfly index j at stage s. The modulus FFT_N >> (s+1) is a
    // power of two, so a mask replaces the divide.
    function automatic int tw_exp(input int j, input int s, input int fft_n);
        return (j & ((fft_n >> (s + 1)) - 1)) << s;
    endfunction

    // Negate the imag field (low nbits) of a {real, imag} word; the most negative
    // value saturates to the most positive one. Real field passes through.
    function automatic logic [63:0] conj_sat(input logic [63:0] word, input int nbits);
        logic [63:0] mask;
        logic [63:0] im;
        logic [63:0] res;
        mask = (64'd1 << nbits) - 64'd1;
        im   = word & mask;
        if (im == (64'd1 << (nbits - 1))) begin
            res = mask >> 1;
        end else begin
            res = (~im + 64'd1) & mask;
        end
        return (word & ~mask) | res;
    endfunction

endpackage

// File: rtl/twiddle_vec_gen_if.sv
// Handshake bundle between the FFT sequencer and the twiddle vector generator.
interface twiddle_vec_gen_if #(
    parameter int NBITS = 11,
    parameter int N     = 32,
    parameter int FFT_N = 128
);
    localparam int LOG2N = $clog2(FFT_N);
    localparam int TW    = FFT_N / 2;
    localparam int NG    = TW / N;

    logic                       tw_wr_en;
    logic [$clog2(TW)-1:0]      tw_wr_addr;
    logic [2*NBITS-1:0]         tw_wr_data;
    logic                       tw_wr_ready;
    logic                       req_valid;
    logic                       req_ready;
    logic [$clog2(LOG2N)-1:0]   req_stage;
    logic [$clog2(NG):0]        req_group;
    logic                       req_inv;
    logic                       out_valid;
    logic                       out_ready;
    logic [NBITS*N*2-1:0]       coeff_data;
    logic                       req_err;

    modport master (
        output tw_wr_en, tw_wr_addr, tw_wr_data, req_valid, req_stage, req_group, req_inv,
               out_ready,
        input  tw_wr_ready, req_ready, out_valid, coeff_data, req_err
    );

    modport slave (
        input  tw_wr_en, tw_wr_addr, tw_wr_data, req_valid, req_stage, req_group, req_inv,
               out_ready,
        output tw_wr_ready, req_ready, out_valid, coeff_data, req_err
    );
endinterface

// File: rtl/twiddle_lut.sv
// Loadable twiddle table with L combinational read ports and optional conjugation.
module twiddle_lut
    import fft_pkg::*;
#(
    parameter int NBITS = 11,
    parameter int FFT_N = 128,
    parameter int L     = 8,
    localparam int TW   = FFT_N / 2,
    localparam int AW   = $clog2(TW),
    localparam int W    = 2 * NBITS
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr [L],
    input  logic          inv,
    output logic [W-1:0]  rd_data [L]
);

    logic [W-1:0] table_q [TW];

    // Table write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    // Parallel lookups, conjugated with saturation for inverse transforms.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            if (inv) begin
                rd_data[i] = W'(conj_sat(64'(table_q[rd_addr[i]]), NBITS));
            end else begin
                rd_data[i] = table_q[rd_addr[i]];
            end
        end
    end

endmodule

// File: rtl/twiddle_vec_gen.sv
// Twiddle coefficient vector generator: assembles an N-lane coefficient vector for a
// (stage, group) request, L lanes per cycle, and holds it until the consumer takes it.
module twiddle_vec_gen
    import fft_pkg::*;
#(
    parameter int NBITS = 11,
    parameter int N     = 32,
    parameter int FFT_N = 128,
    parameter int L     = 8
) (
    input logic             clk,
    input logic             rst,
    twiddle_vec_gen_if.slave bus
);

    localparam int LOG2N = $clog2(FFT_N);
    localparam int TW    = FFT_N / 2;
    localparam int NG    = TW / N;
    localparam int AW    = $clog2(TW);
    localparam int W     = 2 * NBITS;
    localparam int NCH   = N / L;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW    = $clog2(LOG2N);
    localparam int GW    = $clog2(NG) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [GW-1:0]    group_q, group_d;
    logic             inv_q, inv_d;
    logic [W*N-1:0]   coeff_q, coeff_d;
    logic             err_q, err_d;
    logic             req_ok;
    logic [AW-1:0]    rd_addr [L];
    logic [W-1:0]     rd_data [L];

    twiddle_lut #(
        .NBITS (NBITS),
        .FFT_N (FFT_N),
        .L     (L)
    ) u_lut (
        .clk     (clk),
        .wr_en   (bus.tw_wr_en && (state_q == IDLE)),
        .wr_addr (bus.tw_wr_addr),
        .wr_data (bus.tw_wr_data),
        .rd_addr (rd_addr),
        .inv     (inv_q),
        .rd_data (rd_data)
    );

    assign req_ok = (int'(bus.req_stage) < LOG2N) && (int'(bus.req_group) < NG);

    // Table addresses for the lanes of the current chunk.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            rd_addr[i] = AW'(tw_exp(int'(group_q) * N + int'(cnt_q) * L + i,
                                    int'(stage_q), FFT_N));
        end
    end

    // Next-state: request acceptance, chunk fill and hold-until-taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        group_d = group_q;
        inv_d   = inv_q;
        coeff_d = coeff_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_ok) begin
                        stage_d = bus.req_stage;
                        group_d = bus.req_group;
                        inv_d   = bus.req_inv;
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                for (int i = 0; i < L; i++) begin
                    coeff_d[(int'(cnt_q) * L + i) * W +: W] = rd_data[i];
                end
                if (int'(cnt_q) == NCH - 1) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any partial vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            group_q <= '0;
            inv_q   <= 1'b0;
            coeff_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            group_q <= group_d;
            inv_q   <= inv_d;
            coeff_q <= coeff_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid   = (state_q == HOLD);
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.tw_wr_ready = (state_q == IDLE);
    assign bus.coeff_data  = coeff_q;
    assign bus.req_err     = err_q;

endmodule
